// File: rtl/inv_sbox_layer_pkg.sv
// Shared definitions for the decrypt-path inverse substitution layer:
// nibble width, FSM encoding, and the inverse/forward 4-bit S-box tables.
package inv_sbox_layer_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SBOX_N   = 16;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // FSM encoding kept as plain constants so older tools and scripts that
    // match on the raw codes keep working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Inverse S-box, indexed by input nibble.
    localparam nibble_t INV_SBOX [SBOX_N] = '{
        4'hA, 4'hB, 4'h3, 4'h6, 4'hD, 4'h4, 4'h7, 4'h8,
        4'hF, 4'h1, 4'hC, 4'hE, 4'h0, 4'h2, 4'h9, 4'h5
    };

    // Forward S-box of the encrypt path; INV_SBOX[FWD_SBOX[x]] == x.
    // Not used by the decrypt hardware, kept here so models share one source.
    localparam nibble_t FWD_SBOX [SBOX_N] = '{
        4'hC, 4'h9, 4'hD, 4'h2, 4'h5, 4'hF, 4'h3, 4'h6,
        4'h7, 4'hE, 4'h0, 4'h1, 4'hA, 4'h4, 4'hB, 4'h8
    };

    function automatic nibble_t invSboxLookup(input nibble_t x);
        return INV_SBOX[x];
    endfunction

    function automatic nibble_t fwdSboxLookup(input nibble_t x);
        return FWD_SBOX[x];
    endfunction

endpackage

// File: rtl/inv_sbox_layer_sbox.sv
// One inverse S-box lane: a pure 4-bit combinational lookup.
module inv_sbox
    import inv_sbox_layer_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibIn,
    output logic [NIBBLE_W-1:0] nibOut
);

    assign nibOut = invSboxLookup(nibIn);

endmodule

// File: rtl/inv_sbox_layer.sv
// Iterative inverse substitution layer. A captured state is rotated right by
// LANES nibbles per cycle, the outgoing low slice passing through the inverse
// S-box lanes and re-entering at the top. After NCYC rotations every nibble has
// been substituted exactly once and the block is back in its original order.
module inv_sbox_layer
    import inv_sbox_layer_pkg::*;
#(
    parameter int BLOCK_W = 64,
    parameter int LANES   = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    localparam int SLICE_W = NIBBLE_W * LANES;
    localparam int NCYC    = BLOCK_W / SLICE_W;
    localparam int CNT_W   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    // Elaboration-time guard: the rotation only returns to the original nibble
    // order when the block is a whole number of lane slices.
    if ((LANES < 1) || (BLOCK_W % SLICE_W) != 0) begin : gParamCheck
        $error("inv_sbox_layer: BLOCK_W must be a positive multiple of 4*LANES");
    end

    logic [1:0]         state;
    logic [CNT_W-1:0]   laneCnt;
    logic [BLOCK_W-1:0] blockReg;
    logic [SLICE_W-1:0] subSlice;
    logic [BLOCK_W-1:0] rotNext;
    logic               acceptIn;

    // Substitution lanes operate on the lowest slice of the rotating register.
    for (genvar l = 0; l < LANES; l++) begin : gLane
        inv_sbox uLane (
            .nibIn  (blockReg[l*NIBBLE_W +: NIBBLE_W]),
            .nibOut (subSlice[l*NIBBLE_W +: NIBBLE_W])
        );
    end

    // Substituted slice re-enters at the top; with a single slice per block
    // there is nothing left to shift down.
    if (NCYC == 1) begin : gRotSingle
        assign rotNext = subSlice;
    end else begin : gRotMulti
        assign rotNext = {subSlice, blockReg[BLOCK_W-1:SLICE_W]};
    end

    assign acceptIn  = in_valid && (state == ST_IDLE);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_SUB) || (state == ST_DONE);
    assign out_data  = blockReg;

    // FSM, lane counter and rotate register; reset aborts any in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            laneCnt  <= '0;
            blockReg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acceptIn) begin
                        blockReg <= in_data;
                        laneCnt  <= '0;
                        state    <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    blockReg <= rotNext;
                    if (laneCnt == CNT_LAST) begin
                        laneCnt <= '0;
                        state   <= ST_DONE;
                    end else begin
                        laneCnt <= laneCnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
